// File: rtl/dct_dma_sched.sv
// dct_dma_sched: splits one host DMA job into beat-aligned chunks and
// issues lock-stepped read/write DMA starts, advancing once both engines finish.
module dct_dma_sched #(
    parameter int ADDR_W     = 32,
    parameter int BEAT_BYTES = 32
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              job_start,
    input  logic              job_abort,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W-1:0] total_byte,
    input  logic [ADDR_W-1:0] chunk_byte,
    output logic              busy,
    output logic              job_done,
    output logic              aborted,
    output logic [15:0]       chunk_cnt,
    output logic              rd_start,
    output logic [ADDR_W-1:0] rd_mem,
    output logic [ADDR_W-1:0] rd_byte,
    input  logic              rd_done,
    output logic              wr_start,
    output logic [ADDR_W-1:0] wr_mem,
    output logic [ADDR_W-1:0] wr_byte,
    input  logic              wr_done
);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, NEXT, DONE} state_t;
    localparam logic [ADDR_W-1:0] MASK = ~ADDR_W'(BEAT_BYTES - 1);
    state_t state, state_n;
    logic [ADDR_W-1:0] total_t, chunk_t, chunk_eff, chunk, remain, remain_n, issue_len;
    logic rd_f, wr_f, abort_p, rd_hit, wr_hit, abort_n;
    always_comb begin
        total_t   = total_byte & MASK;
        chunk_t   = chunk_byte & MASK;
        chunk_eff = (chunk_t == '0) ? total_t : chunk_t;
        remain_n  = remain - rd_byte;
        rd_hit    = rd_f | rd_done;
        wr_hit    = wr_f | wr_done;
        abort_n   = abort_p | job_abort;
        // chunk length for the ISSUE being entered: fresh job or the remainder after NEXT
        issue_len = (state == IDLE) ? ((chunk_eff < total_t) ? chunk_eff : total_t)
                                    : ((chunk < remain_n) ? chunk : remain_n);
        state_n   = state;
        case (state)
            IDLE:    if (job_start) state_n = (total_t != '0) ? ISSUE : DONE;
            ISSUE:   state_n = WAIT;
            WAIT:    if (rd_hit && wr_hit) state_n = NEXT;
            NEXT:    state_n = (remain_n == '0 || abort_n) ? DONE : ISSUE;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            job_done  <= 1'b0;
            aborted   <= 1'b0;
            chunk_cnt <= '0;
            rd_start  <= 1'b0;
            wr_start  <= 1'b0;
            rd_mem    <= '0;
            wr_mem    <= '0;
            rd_byte   <= '0;
            wr_byte   <= '0;
            chunk     <= '0;
            remain    <= '0;
            rd_f      <= 1'b0;
            wr_f      <= 1'b0;
            abort_p   <= 1'b0;
        end else begin
            state    <= state_n;
            busy     <= state_n != IDLE;
            rd_start <= state_n == ISSUE;
            wr_start <= state_n == ISSUE;
            job_done <= state_n == DONE;
            if (state == IDLE && job_start) begin
                chunk     <= chunk_eff;
                remain    <= total_t;
                chunk_cnt <= '0;
                aborted   <= 1'b0;
                abort_p   <= 1'b0;
                rd_f      <= 1'b0;
                wr_f      <= 1'b0;
            end
            // descriptors only move when a new chunk is issued, so DMAs may latch them any time
            if (state_n == ISSUE) begin
                rd_byte <= issue_len;
                wr_byte <= issue_len;
                rd_mem  <= (state == IDLE) ? src_addr : rd_mem + rd_byte;
                wr_mem  <= (state == IDLE) ? dst_addr : wr_mem + wr_byte;
            end
            if (state == ISSUE || state == WAIT) begin
                rd_f    <= rd_hit;
                wr_f    <= wr_hit;
                abort_p <= abort_n;
            end
            if (state == NEXT) begin
                remain    <= remain_n;
                chunk_cnt <= chunk_cnt + 16'd1;
                rd_f      <= 1'b0;
                wr_f      <= 1'b0;
            end
            if (state == NEXT && state_n == DONE) aborted <= abort_n;
        end
    end
endmodule

// File: tb/tb_dct_dma_sched.sv
// tb_dct_dma_sched: directed job vectors with an echoing DMA responder,
// plus hand sequences for reset, stray dones and idle behaviour.
module tb_dct_dma_sched;
    logic ap_clk = 1'b0, ap_rst_n = 1'b0, job_start = 1'b0, job_abort = 1'b0;
    logic rd_done = 1'b0, wr_done = 1'b0;
    logic [31:0] src_addr = '0, dst_addr = '0, total_byte = '0, chunk_byte = '0;
    logic busy, job_done, aborted, rd_start, wr_start;
    logic [15:0] chunk_cnt;
    logic [31:0] rd_mem, rd_byte, wr_mem, wr_byte;
    int n_cmp = 0, n_fail = 0;

    typedef struct {
        logic [31:0] src, dst, tot, ch;
        int rd_d, wr_d, n;
        logic [31:0] len0, last;
        int cnt, abort_k;
        bit ab, poke;
    } vec_t;
    vec_t vecs[13];

    dct_dma_sched dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .job_start(job_start), .job_abort(job_abort),
        .src_addr(src_addr), .dst_addr(dst_addr), .total_byte(total_byte), .chunk_byte(chunk_byte),
        .busy(busy), .job_done(job_done), .aborted(aborted), .chunk_cnt(chunk_cnt),
        .rd_start(rd_start), .rd_mem(rd_mem), .rd_byte(rd_byte), .rd_done(rd_done),
        .wr_start(wr_start), .wr_mem(wr_mem), .wr_byte(wr_byte), .wr_done(wr_done)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_job(input vec_t v);
        int k = 0, rc = -1, wc = -1, ac = -1, last_d = -100, t = 0;
        bit rf = 0, wf = 0, got = 0;
        logic [31:0] el;
        @(negedge ap_clk);
        src_addr = v.src; dst_addr = v.dst; total_byte = v.tot; chunk_byte = v.ch;
        job_start = 1'b1;
        while (!got && t < 400) begin
            @(negedge ap_clk);
            t++;
            job_start = 1'b0; rd_done = 1'b0; wr_done = 1'b0;
            if (v.poke && t == 3) begin
                job_start = 1'b1; src_addr = 32'hdead0000; total_byte = 32'h20;
            end
            if (rd_start) begin
                el = (k == v.n - 1) ? v.last : v.len0;
                chk("wr_start_pair", {31'd0, wr_start}, 32'd1);
                chk("start_cycle", 32'(t), (k == 0) ? 32'd1 : 32'(last_d + 2));
                chk("rd_mem", rd_mem, v.src + 32'(k) * v.len0);
                chk("wr_mem", wr_mem, v.dst + 32'(k) * v.len0);
                chk("rd_byte", rd_byte, el);
                chk("wr_byte", wr_byte, el);
                rc = v.rd_d; wc = v.wr_d; rf = 0; wf = 0;
                if (k + 1 == v.abort_k) ac = 1;
                k++;
            end
            if (ac == 0) begin job_abort = 1'b1; ac = -1; end else if (ac > 0) ac--;
            if (rc == 0) begin rd_done = 1'b1; rc = -1; rf = 1; if (wf) last_d = t; end
            else if (rc > 0) rc--;
            if (wc == 0) begin wr_done = 1'b1; wc = -1; wf = 1; if (rf) last_d = t; end
            else if (wc > 0) wc--;
            if (job_done) begin
                got = 1;
                chk("done_cycle", 32'(t), (v.n == 0) ? 32'd1 : 32'(last_d + 2));
                chk("start_count", 32'(k), 32'(v.n));
                chk("chunk_cnt", {16'd0, chunk_cnt}, 32'(v.cnt));
                chk("aborted", {31'd0, aborted}, {31'd0, v.ab});
                chk("busy_in_done", {31'd0, busy}, 32'd1);
                job_abort = 1'b0;
            end
        end
        if (!got) chk("job_done_timeout", 32'(t), 32'd0);
        @(negedge ap_clk);
        rd_done = 1'b0; wr_done = 1'b0;
        chk("idle_after_done", {30'd0, busy, job_done}, 32'd0);
    endtask

    initial begin
        //           src           dst           tot      ch       rd wr n  len0     last     cnt ab_k ab poke
        vecs[0]  = '{32'h1000,     32'h8000,     32'h300, 32'h100, 5, 5, 3, 32'h100, 32'h100, 3, 0, 0, 0};
        vecs[1]  = '{32'h2000,     32'h9000,     32'h2A0, 32'h100, 2, 6, 3, 32'h100, 32'h0A0, 3, 0, 0, 0};
        vecs[2]  = '{32'h2000,     32'h9000,     32'h2A7, 32'h100, 2, 6, 3, 32'h100, 32'h0A0, 3, 0, 0, 0};
        vecs[3]  = '{32'h3000,     32'hA000,     32'h010, 32'h100, 1, 1, 0, 32'h0,   32'h0,   0, 0, 0, 0};
        vecs[4]  = '{32'h3000,     32'hA000,     32'h400, 32'h000, 3, 2, 1, 32'h400, 32'h400, 1, 0, 0, 0};
        vecs[5]  = '{32'h0040,     32'h0100,     32'h300, 32'h13F, 1, 3, 3, 32'h120, 32'h0C0, 3, 0, 0, 0};
        vecs[6]  = '{32'h5000,     32'h6000,     32'h200, 32'h100, 3, 3, 2, 32'h100, 32'h100, 2, 0, 0, 0};
        vecs[7]  = '{32'h5000,     32'h6000,     32'h200, 32'h100, 0, 4, 2, 32'h100, 32'h100, 2, 0, 0, 0};
        vecs[8]  = '{32'h7000,     32'h7800,     32'h1000, 32'h100, 5, 5, 2, 32'h100, 32'h100, 2, 2, 1, 0};
        vecs[9]  = '{32'h1000,     32'h8000,     32'h300, 32'h100, 5, 5, 3, 32'h100, 32'h100, 3, 0, 0, 0};
        vecs[10] = '{32'hC000,     32'hD000,     32'h200, 32'h100, 4, 4, 2, 32'h100, 32'h100, 2, 0, 0, 1};
        vecs[11] = '{32'hFFFFFF80, 32'hFFFFFFC0, 32'h100, 32'h080, 1, 2, 2, 32'h080, 32'h080, 2, 0, 0, 0};
        vecs[12] = '{32'h4400,     32'h4800,     32'h040, 32'h100, 1, 0, 1, 32'h040, 32'h040, 1, 0, 0, 0};
        #12;
        chk("rst_flags", {27'd0, busy, job_done, aborted, rd_start, wr_start}, 32'd0);
        chk("rst_cnt", {16'd0, chunk_cnt}, 32'd0);
        chk("rst_rd_mem", rd_mem, 32'd0);
        chk("rst_rd_byte", rd_byte, 32'd0);
        chk("rst_wr_mem", wr_mem, 32'd0);
        chk("rst_wr_byte", wr_byte, 32'd0);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        for (int i = 0; i < 13; i++) run_job(vecs[i]);
        // done pulses arriving while idle must not pre-arm the next job
        @(negedge ap_clk);
        rd_done = 1'b1; wr_done = 1'b1;
        @(negedge ap_clk);
        rd_done = 1'b0; wr_done = 1'b0;
        chk("stray_idle", {29'd0, busy, rd_start, wr_start}, 32'd0);
        chk("stray_cnt", {16'd0, chunk_cnt}, 32'd1);
        run_job(vecs[6]);
        // asynchronous reset while waiting on the DMAs
        @(negedge ap_clk);
        src_addr = 32'h4000; dst_addr = 32'h5000; total_byte = 32'h200; chunk_byte = 32'h100;
        job_start = 1'b1;
        @(negedge ap_clk);
        job_start = 1'b0;
        chk("pre_rst_start", {31'd0, rd_start}, 32'd1);
        @(negedge ap_clk);
        @(negedge ap_clk);
        #2 ap_rst_n = 1'b0;
        #1;
        chk("arst_flags", {27'd0, busy, job_done, aborted, rd_start, wr_start}, 32'd0);
        chk("arst_rd_mem", rd_mem, 32'd0);
        chk("arst_rd_byte", rd_byte, 32'd0);
        chk("arst_wr_mem", wr_mem, 32'd0);
        chk("arst_wr_byte", wr_byte, 32'd0);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        run_job(vecs[0]);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
